// File: rtl/mult_result_accum.sv
// Frame accumulator behind the signed 8x8 multiplier: sums ACC_LEN products into a
// single-entry valid/ready output register. Optional clamping via MULT_ACCUM_SATURATE_EN.
module mult_result_accum #(
    parameter int ACC_LEN = 8,
    parameter int ACC_W   = 24
) (
    input  logic                    Clock_20M,
    input  logic                    Rst,
    input  logic                    In_Valid,
    input  logic signed [15:0]      In_Data,
    input  logic                    In_Clear,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic signed [ACC_W-1:0] Out_Data,
    output logic                    Out_Overflow,
    output logic                    Overrun,
    output logic                    Busy,
    output logic [7:0]              Frame_Cnt
);

    typedef enum logic {ST_IDLE, ST_ACC} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    frame_ovf_q, frame_ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    overrun_q, overrun_d;

    logic signed [ACC_W-1:0] acc_base;
    logic                    ovf_base;
    logic signed [ACC_W-1:0] add_res;
    logic                    add_ovf;
    logic                    out_free;

    localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

    function automatic logic signed [ACC_W-1:0] sext_in(input logic signed [15:0] d);
        return ACC_W'(d);
    endfunction

`ifdef MULT_ACCUM_SATURATE_EN
    function automatic logic signed [ACC_W:0] add_wide(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [15:0] b);
        return {a[ACC_W-1], a} + {{(ACC_W-15){b[15]}}, b};
    endfunction

    function automatic logic sum_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    // Clamp toward the sign of the true (ACC_W+1)-bit result.
    function automatic logic signed [ACC_W-1:0] sat_result(input logic signed [ACC_W:0] s);
        if (!sum_ovf(s))
            return s[ACC_W-1:0];
        else if (s[ACC_W])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    logic signed [ACC_W:0] sum_wide;
    always_comb begin
        sum_wide = add_wide(acc_base, In_Data);
        add_res  = sat_result(sum_wide);
        add_ovf  = sum_ovf(sum_wide);
    end
`else
    always_comb begin
        add_res = acc_base + sext_in(In_Data);
        add_ovf = 1'b0;
    end
`endif

    // A new frame starts from zero regardless of any residue in acc_q.
    assign acc_base = (state_q == ST_IDLE) ? '0 : acc_q;
    assign ovf_base = (state_q == ST_IDLE) ? 1'b0 : frame_ovf_q;
    assign out_free = !out_valid_q || Out_Ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        frame_ovf_d = frame_ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        overrun_d   = overrun_q;

        if (out_valid_q && Out_Ready)
            out_valid_d = 1'b0;

        if (In_Clear) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            frame_ovf_d = 1'b0;
        end else if (In_Valid) begin
            if (state_q == ST_IDLE) begin
                state_d     = ST_ACC;
                acc_d       = add_res;
                cnt_d       = 8'd1;
                frame_ovf_d = add_ovf;
            end else if (cnt_q == LAST_CNT) begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                frame_ovf_d = 1'b0;
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = add_res;
                    out_ovf_d   = ovf_base | add_ovf;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                acc_d       = add_res;
                cnt_d       = cnt_q + 8'd1;
                frame_ovf_d = ovf_base | add_ovf;
            end
        end
    end

    always_ff @(posedge Clock_20M) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            frame_ovf_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            frame_ovf_q <= frame_ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            overrun_q   <= overrun_d;
        end
    end

    assign Out_Valid    = out_valid_q;
    assign Out_Data     = out_data_q;
    assign Out_Overflow = out_ovf_q;
    assign Overrun      = overrun_q;
    assign Busy         = (state_q == ST_ACC);
    assign Frame_Cnt    = cnt_q;

endmodule

// File: tb/tb_mult_result_accum.sv
// Directed bench for mult_result_accum: a vector table on an ACC_LEN=4 instance plus
// hand sequences on ACC_LEN=8, ACC_LEN=2 and a 16-bit instance for the overflow case.
module tb_mult_result_accum;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_clear, out_ready;
    logic signed [15:0] in_data;

    logic               v8, ov8, or8, b8, v4, ov4, or4, b4, v2, ov2, or2, b2, vs, ovs, ors, bs;
    logic signed [23:0] d8, d4, d2;
    logic signed [15:0] ds;
    logic [7:0]         c8, c4, c2, cs;

    int n_vec = 0;
    int n_err = 0;

    always #25 clk = ~clk;

    mult_result_accum #(.ACC_LEN(8), .ACC_W(24)) u8 (
        .Clock_20M(clk), .Rst(rst), .In_Valid(in_valid), .In_Data(in_data), .In_Clear(in_clear),
        .Out_Valid(v8), .Out_Ready(out_ready), .Out_Data(d8), .Out_Overflow(ov8),
        .Overrun(or8), .Busy(b8), .Frame_Cnt(c8));

    mult_result_accum #(.ACC_LEN(4), .ACC_W(24)) u4 (
        .Clock_20M(clk), .Rst(rst), .In_Valid(in_valid), .In_Data(in_data), .In_Clear(in_clear),
        .Out_Valid(v4), .Out_Ready(out_ready), .Out_Data(d4), .Out_Overflow(ov4),
        .Overrun(or4), .Busy(b4), .Frame_Cnt(c4));

    mult_result_accum #(.ACC_LEN(2), .ACC_W(24)) u2 (
        .Clock_20M(clk), .Rst(rst), .In_Valid(in_valid), .In_Data(in_data), .In_Clear(in_clear),
        .Out_Valid(v2), .Out_Ready(out_ready), .Out_Data(d2), .Out_Overflow(ov2),
        .Overrun(or2), .Busy(b2), .Frame_Cnt(c2));

    mult_result_accum #(.ACC_LEN(2), .ACC_W(16)) us (
        .Clock_20M(clk), .Rst(rst), .In_Valid(in_valid), .In_Data(in_data), .In_Clear(in_clear),
        .Out_Valid(vs), .Out_Ready(out_ready), .Out_Data(ds), .Out_Overflow(ovs),
        .Overrun(ors), .Busy(bs), .Frame_Cnt(cs));

    typedef struct {
        logic v; logic c; logic signed [15:0] d; logic r;
        logic ev; int ed; int ecnt; logic eb; logic eo;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(int v, int c, int d, int r, int ev, int ed, int ecnt, int eb, int eo);
        vec_t m;
        m.v = v[0]; m.c = c[0]; m.d = 16'(d); m.r = r[0];
        m.ev = ev[0]; m.ed = ed; m.ecnt = ecnt; m.eb = eb[0]; m.eo = eo[0];
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic c, input int d, input logic r);
        in_valid  = v;
        in_clear  = c;
        in_data   = 16'(d);
        out_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Signed/gapped frame, handshake drain, then clear-with-valid at Frame_Cnt=3.
        tbl[0]  = mk(1, 0, -32768, 1, 0, 0,      1, 1, 0);
        tbl[1]  = mk(1, 0, 127,    1, 0, 0,      2, 1, 0);
        tbl[2]  = mk(0, 0, 0,      1, 0, 0,      2, 1, 0);
        tbl[3]  = mk(0, 0, 0,      1, 0, 0,      2, 1, 0);
        tbl[4]  = mk(0, 0, 0,      1, 0, 0,      2, 1, 0);
        tbl[5]  = mk(1, 0, -1,     1, 0, 0,      3, 1, 0);
        tbl[6]  = mk(1, 0, 16129,  1, 1, -16513, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0,      1, 0, -16513, 0, 0, 0);
        tbl[8]  = mk(1, 0, 10,     1, 0, -16513, 1, 1, 0);
        tbl[9]  = mk(1, 0, 20,     1, 0, -16513, 2, 1, 0);
        tbl[10] = mk(1, 0, 30,     1, 0, -16513, 3, 1, 0);
        tbl[11] = mk(1, 1, 40,     1, 0, -16513, 0, 0, 0);
        tbl[12] = mk(0, 0, 0,      1, 0, -16513, 0, 0, 0);

        do_reset();
        chk("rst_valid", int'(v8), 0);
        chk("rst_data", int'(d8), 0);
        chk("rst_cnt", int'(c8), 0);
        chk("rst_busy", int'(b8), 0);
        chk("rst_overrun", int'(or8), 0);
        chk("rst_ovf", int'(ov8), 0);

        // Basic frame: eight products of 100.
        for (int k = 1; k <= 8; k++) begin
            drive(1, 0, 100, 0);
            step();
            if (k < 8) begin
                chk($sformatf("basic_busy_%0d", k), int'(b8), 1);
                chk($sformatf("basic_valid_%0d", k), int'(v8), 0);
                chk($sformatf("basic_cnt_%0d", k), int'(c8), k);
            end
        end
        drive(0, 0, 0, 0);
        chk("basic_valid", int'(v8), 1);
        chk("basic_data", int'(d8), 800);
        chk("basic_busy_end", int'(b8), 0);
        chk("basic_cnt_end", int'(c8), 0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].c, int'(tbl[i].d), tbl[i].r);
            step();
            chk($sformatf("tbl%0d_valid", i), int'(v4), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), int'(d4), tbl[i].ed);
            chk($sformatf("tbl%0d_cnt", i), int'(c4), tbl[i].ecnt);
            chk($sformatf("tbl%0d_busy", i), int'(b4), int'(tbl[i].eb));
            chk($sformatf("tbl%0d_overrun", i), int'(or4), int'(tbl[i].eo));
        end
        chk("wrap_ovf_flag", int'(ov4), 0);

        // Backpressure: second frame dropped, Overrun sticks.
        do_reset();
        drive(1, 0, 5, 0); step();
        drive(1, 0, 6, 0); step();
        chk("bp_valid1", int'(v2), 1);
        chk("bp_data1", int'(d2), 11);
        drive(1, 0, 7, 0); step();
        drive(1, 0, 8, 0); step();
        chk("bp_valid2", int'(v2), 1);
        chk("bp_data2", int'(d2), 11);
        chk("bp_overrun", int'(or2), 1);
        drive(0, 0, 0, 1); step();
        chk("bp_drained", int'(v2), 0);
        chk("bp_overrun_sticky", int'(or2), 1);
        drive(0, 0, 0, 1); step();
        chk("bp_no_second", int'(v2), 0);

        // Back-to-back: transfer and completion on the same edge.
        do_reset();
        drive(1, 0, 5, 0); step();
        drive(1, 0, 6, 0); step();
        chk("b2b_first", int'(d2), 11);
        drive(1, 0, 3, 0); step();
        chk("b2b_hold", int'(d2), 11);
        drive(1, 0, 4, 1); step();
        chk("b2b_valid", int'(v2), 1);
        chk("b2b_data", int'(d2), 7);
        chk("b2b_overrun", int'(or2), 0);
        drive(0, 0, 0, 1); step();
        chk("b2b_drained", int'(v2), 0);

        // Reset while holding a result.
        drive(1, 0, 1, 0); step();
        drive(1, 0, 2, 0); step();
        chk("rstmid_valid_pre", int'(v2), 1);
        chk("rstmid_data_pre", int'(d2), 3);
        rst = 1'b1;
        drive(1, 0, 9, 0);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("rstmid_valid", int'(v2), 0);
        chk("rstmid_data", int'(d2), 0);
        chk("rstmid_cnt", int'(c2), 0);

        // Overflow at ACC_W=16.
        do_reset();
        drive(1, 0, 32767, 0); step();
        drive(1, 0, 32767, 0); step();
        drive(0, 0, 0, 0);
        chk("ovf_valid", int'(vs), 1);
`ifdef MULT_ACCUM_SATURATE_EN
        chk("ovf_data", int'(ds), 32767);
        chk("ovf_flag", int'(ovs), 1);
`else
        chk("ovf_data", int'(ds), -2);
        chk("ovf_flag", int'(ovs), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
